// File: rtl/timing_sequencer_if.sv
// Control-unit <-> timing sequencer connection: sequencing controls in,
// T-state vector and status out. The master is the control unit.
`timescale 1ns/1ps

interface timing_sequencer_if #(
    parameter int NUM_T      = 4,
    parameter int ICNT_WIDTH = 16
);
    localparam int IDX_W = $clog2(NUM_T);

    // Sequencing controls from the control unit
    logic                  clr_timer;
    logic                  hlt;
    logic                  run;
    logic                  step;
    logic                  mem_cycle;
    logic                  ready;

    // Timing and status back to the control unit
    logic [NUM_T-1:0]      T;
    logic [IDX_W-1:0]      t_index;
    logic                  fetch;
    logic                  halted;
    logic                  wait_active;
    logic                  bus_error;
    logic [ICNT_WIDTH-1:0] instr_count;

    modport master (
        output clr_timer, hlt, run, step, mem_cycle, ready,
        input  T, t_index, fetch, halted, wait_active, bus_error, instr_count
    );

    modport slave (
        input  clr_timer, hlt, run, step, mem_cycle, ready,
        output T, t_index, fetch, halted, wait_active, bus_error, instr_count
    );
endinterface

// File: rtl/timing_sequencer.sv
// One-hot T-state generator with memory wait-state stretching, wait timeout,
// halt/run/single-step control and a completed-instruction counter.
// All status outputs are decoded only from registered state, so they carry
// no combinational path from the inputs and clear as soon as reset asserts.
`timescale 1ns/1ps

module timing_sequencer #(
    parameter int NUM_T        = 4,
    parameter int WAIT_TIMEOUT = 15,
    parameter int ICNT_WIDTH   = 16
) (
    input  logic                clk,
    input  logic                reset,
    timing_sequencer_if.slave   bus
);
    localparam int IDX_W  = $clog2(NUM_T);
    localparam int WCNT_W = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_WAIT,
        S_HALT
    } state_t;

    state_t                state;
    logic [IDX_W-1:0]      idx;
    logic [WCNT_W-1:0]     wait_cnt;
    logic                  step_flag;
    logic                  bus_error;
    logic [ICNT_WIDTH-1:0] instr_count;

    logic                  stall;
    logic                  advance;
    logic                  complete;
    logic                  timeout;

    // Decide whether this edge moves the T-state forward and whether that ends an instruction
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        stall    = 1'b0;
        advance  = 1'b0;
        complete = 1'b0;
        timeout  = 1'b0;
        stall    = bus.mem_cycle && !bus.ready;
        if (state == S_RUN) begin
            advance = !stall && !bus.hlt;
        end else if (state == S_WAIT) begin
            advance = bus.ready;
        end
        complete = bus.clr_timer || (idx == IDX_W'(NUM_T - 1));
        timeout  = (WAIT_TIMEOUT != 0) && (wait_cnt == WCNT_W'(WAIT_TIMEOUT));
    end

    // Sequencer FSM: state, T index, wait counter, step flag, error flag and instruction count
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            wait_cnt    <= '0;
            step_flag   <= 1'b0;
            bus_error   <= 1'b0;
            instr_count <= '0;
        end else begin
            case (state)
                S_IDLE: state <= S_RUN;
                S_RUN: begin
                    // An outstanding access takes priority over a halt request
                    if (stall) begin
                        state    <= S_WAIT;
                        wait_cnt <= WCNT_W'(1);
                    end else if (bus.hlt) begin
                        state <= S_HALT;
                    end
                end
                S_WAIT: begin
                    if (!bus.ready) begin
                        if (timeout) begin
                            state     <= S_HALT;
                            bus_error <= 1'b1;
                        end else if (wait_cnt != '1) begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    // run wins over step; clr_timer has no effect while halted
                    if (bus.run) begin
                        state     <= S_RUN;
                        idx       <= '0;
                        bus_error <= 1'b0;
                        step_flag <= 1'b0;
                    end else if (bus.step) begin
                        state     <= S_RUN;
                        idx       <= '0;
                        bus_error <= 1'b0;
                        step_flag <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Shared T-state advance for RUN and for WAIT when memory becomes ready
            if (advance) begin
                if (complete) begin
                    idx         <= '0;
                    instr_count <= instr_count + 1'b1;
                    if (step_flag) begin
                        state     <= S_HALT;
                        step_flag <= 1'b0;
                    end else begin
                        state <= S_RUN;
                    end
                end else begin
                    idx   <= idx + 1'b1;
                    state <= S_RUN;
                end
            end
        end
    end

    // Output decode from registered state only
    always_comb begin
        bus.T           = (state == S_IDLE) ? '0 : (NUM_T'(1) << idx);
        bus.t_index     = idx;
        bus.fetch       = (state == S_RUN) && (idx == '0);
        bus.halted      = (state == S_HALT);
        bus.wait_active = (state == S_WAIT);
        bus.bus_error   = bus_error;
        bus.instr_count = instr_count;
    end
endmodule

// File: tb/tb_timing_sequencer.sv
// Self-checking bench for timing_sequencer (NUM_T=4, WAIT_TIMEOUT=15).
// Expected output snapshots are queued as stimulus is applied and compared
// against the DUT one time step after the clock edge that produces them.
`timescale 1ns/1ps

module tb_timing_sequencer;
    localparam int NUM_T  = 4;
    localparam int ICNT_W = 16;
    localparam int WT     = 15;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    timing_sequencer_if #(.NUM_T(NUM_T), .ICNT_WIDTH(ICNT_W)) bus ();

    timing_sequencer #(
        .NUM_T        (NUM_T),
        .WAIT_TIMEOUT (WT),
        .ICNT_WIDTH   (ICNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        logic [3:0]  t;
        logic        fetch;
        logic        halted;
        logic        wait_a;
        logic        berr;
        logic [15:0] icnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected)
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        else
            n_pass++;
    endtask

    function automatic logic [31:0] onehot_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++)
            if (v[i]) return 32'(i);
        return 32'd0;
    endfunction

    task automatic push(input string tag, input logic [3:0] t, input logic f, input logic h,
                        input logic w, input logic b, input logic [15:0] ic);
        exp_t e;
        e.tag = tag; e.t = t; e.fetch = f; e.halted = h; e.wait_a = w; e.berr = b; e.icnt = ic;
        sb.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        e = sb.pop_front();
        check($sformatf("%s.T",           e.tag), 32'(bus.T),           32'(e.t));
        check($sformatf("%s.t_index",     e.tag), 32'(bus.t_index),     onehot_idx(e.t));
        check($sformatf("%s.fetch",       e.tag), 32'(bus.fetch),       32'(e.fetch));
        check($sformatf("%s.halted",      e.tag), 32'(bus.halted),      32'(e.halted));
        check($sformatf("%s.wait_active", e.tag), 32'(bus.wait_active), 32'(e.wait_a));
        check($sformatf("%s.bus_error",   e.tag), 32'(bus.bus_error),   32'(e.berr));
        check($sformatf("%s.instr_count", e.tag), 32'(bus.instr_count), 32'(e.icnt));
    endtask

    task automatic expect_edge(input string tag, input logic [3:0] t, input logic f, input logic h,
                               input logic w, input logic b, input logic [15:0] ic);
        push(tag, t, f, h, w, b, ic);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic expect_now(input string tag, input logic [3:0] t, input logic f, input logic h,
                              input logic w, input logic b, input logic [15:0] ic);
        push(tag, t, f, h, w, b, ic);
        compare_out();
    endtask

    initial begin
        bus.clr_timer = 1'b0;
        bus.hlt       = 1'b0;
        bus.run       = 1'b0;
        bus.step      = 1'b0;
        bus.mem_cycle = 1'b0;
        bus.ready     = 1'b0;

        // Reset, IDLE, then free-running T sequence with one wrap
        repeat (2) @(posedge clk);
        #1;
        expect_now("reset", 4'b0000, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        expect_now("idle", 4'b0000, 0, 0, 0, 0, 0);
        expect_edge("run_t0", 4'b0001, 1, 0, 0, 0, 0);
        expect_edge("run_t1", 4'b0010, 0, 0, 0, 0, 0);
        expect_edge("run_t2", 4'b0100, 0, 0, 0, 0, 0);
        expect_edge("run_t3", 4'b1000, 0, 0, 0, 0, 0);
        expect_edge("wrap",   4'b0001, 1, 0, 0, 0, 1);

        // Three 2-cycle instructions ended by clr_timer at T1
        for (int k = 0; k < 3; k++) begin
            expect_edge("clr_t1", 4'b0010, 0, 0, 0, 0, 16'(1 + k));
            bus.clr_timer = 1'b1;
            expect_edge("clr_t0", 4'b0001, 1, 0, 0, 0, 16'(2 + k));
            bus.clr_timer = 1'b0;
        end

        // Three wait cycles at T1, then ready advances to T2
        expect_edge("pre_wait", 4'b0010, 0, 0, 0, 0, 4);
        bus.mem_cycle = 1'b1;
        bus.ready     = 1'b0;
        for (int k = 0; k < 3; k++)
            expect_edge("wait", 4'b0010, 0, 0, 1, 0, 4);
        bus.ready = 1'b1;
        expect_edge("wait_done", 4'b0100, 0, 0, 0, 0, 4);
        bus.mem_cycle = 1'b0;
        bus.ready     = 1'b0;
        expect_edge("after_wait_t3", 4'b1000, 0, 0, 0, 0, 4);
        expect_edge("after_wait_t0", 4'b0001, 1, 0, 0, 0, 5);
        expect_edge("to_t1",         4'b0010, 0, 0, 0, 0, 5);

        // Wait timeout: 15 wait cycles, then HALT with bus_error
        bus.mem_cycle = 1'b1;
        for (int k = 0; k < WT; k++)
            expect_edge("timeout_wait", 4'b0010, 0, 0, 1, 0, 5);
        expect_edge("timeout_halt", 4'b0010, 0, 1, 0, 1, 5);
        bus.mem_cycle = 1'b0;
        expect_edge("timeout_hold", 4'b0010, 0, 1, 0, 1, 5);

        // run clears bus_error and restarts at T0
        bus.run = 1'b1;
        expect_edge("resume", 4'b0001, 1, 0, 0, 0, 5);
        bus.run = 1'b0;
        expect_edge("res_t1", 4'b0010, 0, 0, 0, 0, 5);
        expect_edge("res_t2", 4'b0100, 0, 0, 0, 0, 5);

        // hlt at T2 freezes T and the counter; clr_timer is ignored while halted
        bus.hlt = 1'b1;
        expect_edge("hlt", 4'b0100, 0, 1, 0, 0, 5);
        for (int k = 0; k < 10; k++) begin
            bus.clr_timer = (k == 4);
            expect_edge("hlt_hold", 4'b0100, 0, 1, 0, 0, 5);
        end
        bus.clr_timer = 1'b0;

        // Resume with hlt still high: one T0 with fetch, then halted again
        bus.run = 1'b1;
        expect_edge("resume_hlt", 4'b0001, 1, 0, 0, 0, 5);
        bus.run = 1'b0;
        expect_edge("rehalt", 4'b0001, 0, 1, 0, 0, 5);
        bus.hlt = 1'b0;

        // Single step: exactly T0..T3, one completion, back to HALT at T0
        bus.step = 1'b1;
        expect_edge("step_t0", 4'b0001, 1, 0, 0, 0, 5);
        bus.step = 1'b0;
        expect_edge("step_t1", 4'b0010, 0, 0, 0, 0, 5);
        expect_edge("step_t2", 4'b0100, 0, 0, 0, 0, 5);
        expect_edge("step_t3", 4'b1000, 0, 0, 0, 0, 5);
        expect_edge("step_done", 4'b0001, 0, 1, 0, 0, 6);
        expect_edge("step_hold", 4'b0001, 0, 1, 0, 0, 6);

        // run and step together: run wins, continuous RUN
        bus.run  = 1'b1;
        bus.step = 1'b1;
        expect_edge("runstep_t0", 4'b0001, 1, 0, 0, 0, 6);
        bus.run  = 1'b0;
        bus.step = 1'b0;
        expect_edge("runstep_t1",   4'b0010, 0, 0, 0, 0, 6);
        expect_edge("runstep_t2",   4'b0100, 0, 0, 0, 0, 6);
        expect_edge("runstep_t3",   4'b1000, 0, 0, 0, 0, 6);
        expect_edge("runstep_wrap", 4'b0001, 1, 0, 0, 0, 7);
        expect_edge("runstep_t1b",  4'b0010, 0, 0, 0, 0, 7);
        expect_edge("runstep_t2b",  4'b0100, 0, 0, 0, 0, 7);

        // Asynchronous reset in the middle of a wait at T2
        bus.mem_cycle = 1'b1;
        expect_edge("wait_t2", 4'b0100, 0, 0, 1, 0, 7);
        #3;
        reset = 1'b0;
        #1;
        expect_now("async_reset", 4'b0000, 0, 0, 0, 0, 0);
        bus.mem_cycle = 1'b0;
        @(posedge clk);
        #1;
        expect_now("reset_held", 4'b0000, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        expect_now("released", 4'b0000, 0, 0, 0, 0, 0);
        expect_edge("restart", 4'b0001, 1, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
